// File: rtl/ftdi_pkg.sv
// Shared definitions for the FT601 receive gateway: FSM encoding, bus widths
// and the default read-burst limit.
package ftdi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_READ = 2'd2,
    ST_GAP  = 2'd3
  } rx_state_e;

  localparam int BURST_MAX_DEFAULT = 1024;
  localparam int DATA_W            = 32;
  localparam int BE_W              = 4;
  localparam int SESS_W            = 11;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock first-word-fall-through buffer with an occupancy count.
// The head entry is always visible on rd_data while valid is high.
module rx_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = wr_en && (r_count != CW'(DEPTH));
  assign w_pop  = rd_en && (r_count != '0);

  // Storage array; contents need no reset because r_count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rptr];
  assign valid   = (r_count != '0);
  assign count   = r_count;

endmodule

// File: rtl/ftdi_rx_gateway.sv
// FT601 245-mode receive path: bus turnaround/read-strobe FSM feeding an
// FWFT buffer, with burst length and buffer headroom limiting each session.
module ftdi_rx_gateway
  import ftdi_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_MAX  = BURST_MAX_DEFAULT
) (
  input  logic              ftdi_clk,
  input  logic              rst_n,
  input  logic              ftdi_rxf_n,
  input  logic [DATA_W-1:0] ftdi_data,
  input  logic [BE_W-1:0]   ftdi_be,
  output logic              ftdi_oe_n,
  output logic              ftdi_rd_n,
  output logic [DATA_W-1:0] data_out,
  output logic [BE_W-1:0]   data_out_be,
  output logic              data_out_valid,
  input  logic              data_out_ready
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam logic [CW-1:0]     OCC_LIMIT = CW'(FIFO_DEPTH - 2);
  localparam logic [SESS_W-1:0] SESS_MAX  = SESS_W'(BURST_MAX);

  rx_state_e               r_state;
  rx_state_e               w_next;
  logic                    r_oe_n;
  logic                    r_rd_n;
  logic                    r_armed;
  logic [SESS_W-1:0]       r_sess_cnt;
  logic [SESS_W-1:0]       w_sess_next;
  logic                    w_wr;
  logic                    w_pop;
  logic [CW-1:0]           w_occ;
  logic [CW-1:0]           w_occ_next;
  logic [DATA_W+BE_W-1:0]  w_rd_word;

  // Capture only while the strobe is actually on the bus and data is present.
  assign w_wr        = !r_rd_n && !ftdi_rxf_n;
  assign w_pop       = data_out_valid && data_out_ready;
  assign w_sess_next = r_sess_cnt + SESS_W'(w_wr);
  assign w_occ_next  = w_occ + CW'(w_wr) - CW'(w_pop);

  // Next-state logic for the read session.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !ftdi_rxf_n && (w_occ <= OCC_LIMIT)) w_next = ST_TURN;
        else                                                 w_next = ST_IDLE;
      end
      ST_TURN: w_next = ST_READ;
      ST_READ: begin
        if (ftdi_rxf_n || (w_sess_next == SESS_MAX) || (w_occ_next > OCC_LIMIT))
          w_next = ST_GAP;
        else
          w_next = ST_READ;
      end
      ST_GAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State and bus strobes; r_armed holds off the first session one extra edge.
  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_oe_n  <= 1'b1;
      r_rd_n  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      r_oe_n  <= !((w_next == ST_TURN) || (w_next == ST_READ));
      r_rd_n  <= (w_next != ST_READ);
      r_armed <= 1'b1;
    end
  end

  // Per-session capture count.
  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sess_cnt <= '0;
    end else if ((r_state == ST_IDLE) && (w_next == ST_TURN)) begin
      r_sess_cnt <= '0;
    end else if (w_wr) begin
      r_sess_cnt <= w_sess_next;
    end else begin
      r_sess_cnt <= r_sess_cnt;
    end
  end

  rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + BE_W)
  ) u_fifo (
    .clk     (ftdi_clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr),
    .wr_data ({ftdi_be, ftdi_data}),
    .rd_en   (data_out_ready),
    .rd_data (w_rd_word),
    .valid   (data_out_valid),
    .count   (w_occ)
  );

  assign ftdi_oe_n   = r_oe_n;
  assign ftdi_rd_n   = r_rd_n;
  assign data_out    = w_rd_word[DATA_W-1:0];
  assign data_out_be = w_rd_word[DATA_W +: BE_W];

endmodule

// File: tb/tb_ftdi_rx_gateway.sv
// Directed bench: an FT601 source model feeds the gateway, captured words go
// into a scoreboard and are compared in order as the downstream accepts them.
module tb_ftdi_rx_gateway;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxf_n;
  logic [31:0] din;
  logic [3:0]  bein;
  logic        oe_n;
  logic        rd_n;
  logic [31:0] dout;
  logic [3:0]  beout;
  logic        valid;
  logic        ready;

  logic [35:0] src_q[$];
  logic [35:0] exp_q[$];
  bit          rxf_block;
  int          total = 0;
  int          bad   = 0;
  int          run_cnt;
  int          xfer_cnt;

  always #5 clk = ~clk;

  ftdi_rx_gateway #(.FIFO_DEPTH(8), .BURST_MAX(1024)) dut (
    .ftdi_clk       (clk),
    .rst_n          (rst_n),
    .ftdi_rxf_n     (rxf_n),
    .ftdi_data      (din),
    .ftdi_be        (bein),
    .ftdi_oe_n      (oe_n),
    .ftdi_rd_n      (rd_n),
    .data_out       (dout),
    .data_out_be    (beout),
    .data_out_valid (valid),
    .data_out_ready (ready)
  );

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic update_bus();
    rxf_n = rxf_block || (src_q.size() == 0);
    if (src_q.size() != 0) {bein, din} = src_q[0];
    else                   {bein, din} = 36'd0;
  endtask

  // Called at a falling edge with inputs set for the coming rising edge.
  task automatic tick();
    logic [35:0] w;
    chk("valid_vs_sb", 36'(valid), 36'(exp_q.size() != 0));
    chk("occ_max7", 36'(exp_q.size() <= 7), 36'd1);
    chk("rd_implies_oe", 36'(rd_n || !oe_n), 36'd1);
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty_on_pop", 36'(exp_q.size()), 36'd1);
      end else begin
        w = exp_q.pop_front();
        chk("data", {beout, dout}, w);
        xfer_cnt++;
      end
    end
    if (!rd_n && !rxf_n) begin
      exp_q.push_back(src_q.pop_front());
      run_cnt++;
    end
    @(posedge clk);
    #1;
    update_bus();
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] base, input int n, input logic [3:0] last_be);
    for (int i = 0; i < n; i++)
      src_q.push_back({(i == n - 1) ? last_be : 4'hF, base + 32'(i)});
    update_bus();
  endtask

  task automatic drain(input string tag, input int lim);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < lim) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({tag, "_drained"}, 36'(src_q.size() + exp_q.size()), 36'd0);
  endtask

  initial begin
    int first_v, last_v, n, c;
    rst_n = 1'b0; ready = 1'b1; rxf_block = 1'b0;
    run_cnt = 0; xfer_cnt = 0;
    load(32'hA000_0000, 5, 4'b0011);
    repeat (2) @(negedge clk);
    chk("rst_oe_n", 36'(oe_n), 36'd1);
    chk("rst_rd_n", 36'(rd_n), 36'd1);
    chk("rst_valid", 36'(valid), 36'd0);

    // Five-word session straight out of reset
    rst_n = 1'b1;
    tick();
    chk("A_e1_oe_n", 36'(oe_n), 36'd1);
    chk("A_e1_rd_n", 36'(rd_n), 36'd1);
    tick();
    chk("A_turn_oe_n", 36'(oe_n), 36'd0);
    chk("A_turn_rd_n", 36'(rd_n), 36'd1);
    tick();
    chk("A_read_rd_n", 36'(rd_n), 36'd0);
    first_v = -1; last_v = -1;
    for (int i = 0; i < 40; i++) begin
      if (valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (valid && dout == 32'hA000_0004) chk("A_last_be", 36'(beout), 36'(4'b0011));
      if (valid && dout == 32'hA000_0002) chk("A_mid_be", 36'(beout), 36'(4'b1111));
      tick();
    end
    chk("A_xfers", 36'(xfer_cnt), 36'd5);
    chk("A_captures", 36'(run_cnt), 36'd5);
    chk("A_no_gaps", 36'(last_v - first_v + 1), 36'd5);

    // Backpressure: occupancy must stop at 7 of 8
    ready = 1'b0; xfer_cnt = 0;
    load(32'hB000_0000, 12, 4'hF);
    repeat (30) tick();
    chk("B_occ", 36'(exp_q.size()), 36'd7);
    chk("B_rd_n_idle", 36'(rd_n), 36'd1);
    chk("B_oe_n_idle", 36'(oe_n), 36'd1);
    ready = 1'b1;
    drain("B", 100);
    chk("B_xfers", 36'(xfer_cnt), 36'd12);

    // Burst limit at 1024 captures, then a fresh session
    xfer_cnt = 0; run_cnt = 0;
    load(32'hC000_0000, 2000, 4'hF);
    n = 0;
    while (rd_n && n < 10) begin tick(); n++; end
    n = 0;
    while (!rd_n && n < 1100) begin tick(); n++; end
    chk("C_burst", 36'(run_cnt), 36'd1024);
    chk("C_gap_oe_n", 36'(oe_n), 36'd1);
    run_cnt = 0;
    tick();
    chk("C_idle_oe_n", 36'(oe_n), 36'd1);
    chk("C_idle_rd_n", 36'(rd_n), 36'd1);
    tick();
    chk("C_turn_oe_n", 36'(oe_n), 36'd0);
    chk("C_turn_rd_n", 36'(rd_n), 36'd1);
    tick();
    chk("C_resume_rd_n", 36'(rd_n), 36'd0);
    drain("C", 1200);
    chk("C_second_run", 36'(run_cnt), 36'd976);
    chk("C_xfers", 36'(xfer_cnt), 36'd2000);

    // rxf_n rises after three captures
    run_cnt = 0; xfer_cnt = 0;
    load(32'hD000_0000, 10, 4'hF);
    n = 0;
    while (run_cnt < 3 && n < 20) begin tick(); n++; end
    rxf_block = 1'b1;
    update_bus();
    n = 0;
    while (!oe_n && n < 2) begin tick(); n++; end
    chk("D_oe_release", 36'(oe_n), 36'd1);
    chk("D_gap_rd_n", 36'(rd_n), 36'd1);
    repeat (4) tick();
    chk("D_captures", 36'(run_cnt), 36'd3);
    chk("D_idle_oe_n", 36'(oe_n), 36'd1);
    chk("D_sb_empty", 36'(exp_q.size()), 36'd0);

    // rxf_n rises during the turnaround cycle
    rxf_block = 1'b0;
    update_bus();
    n = 0;
    while (oe_n && n < 5) begin tick(); n++; end
    chk("E_turn_rd_n", 36'(rd_n), 36'd1);
    rxf_block = 1'b1;
    update_bus();
    c = run_cnt;
    tick();
    chk("E_read_rd_n", 36'(rd_n), 36'd0);
    tick();
    chk("E_gap_rd_n", 36'(rd_n), 36'd1);
    chk("E_gap_oe_n", 36'(oe_n), 36'd1);
    chk("E_no_capture", 36'(run_cnt - c), 36'd0);
    rxf_block = 1'b0;
    update_bus();
    drain("E", 100);
    chk("DE_xfers", 36'(xfer_cnt), 36'd10);

    // Reset in the middle of a read session
    ready = 1'b0;
    load(32'hF000_0000, 10, 4'hF);
    n = 0;
    while (exp_q.size() < 4 && n < 20) begin tick(); n++; end
    chk("F_in_read", 36'(rd_n), 36'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("F_rst_oe_n", 36'(oe_n), 36'd1);
    chk("F_rst_rd_n", 36'(rd_n), 36'd1);
    chk("F_rst_valid", 36'(valid), 36'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    chk("F_e1_rd_n", 36'(rd_n), 36'd1);
    chk("F_e1_oe_n", 36'(oe_n), 36'd1);
    tick();
    chk("F_e2_rd_n", 36'(rd_n), 36'd1);
    tick();
    chk("F_e3_rd_n", 36'(rd_n), 36'd0);
    drain("F", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ftdi_rx_gateway.md
FTDI_RX_GATEWAY -- requirements
Module: ftdi_rx_gateway

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set the receive buffer depth in 32-bit words; legal values are powers of 2, minimum 4.
REQ-002 Parameter BURST_MAX, default 1024, SHALL set the maximum words read in one read session.
REQ-003 ftdi_clk  in  1: the single clock, FT601 bus clock; all logic is on its rising edge.
REQ-004 rst_n  in  1: asynchronous, active-low reset.
REQ-005 ftdi_rxf_n  in  1: low = FT601 holds receive data.
REQ-006 ftdi_data  in  32: FT601 data bus, input half; the top-level tristate is outside this block.
REQ-007 ftdi_be  in  4: FT601 byte enables accompanying ftdi_data.
REQ-008 ftdi_oe_n  out  1: low = FT601 drives the bus; the top level also uses it as the tristate direction.
REQ-009 ftdi_rd_n  out  1: low = read strobe.
REQ-010 data_out  out  32: received word.
REQ-011 data_out_be  out  4: byte enables of data_out.
REQ-012 data_out_valid  out  1: data_out and data_out_be are valid.
REQ-013 data_out_ready  in  1: downstream accepts the word; a transfer occurs on any edge where valid and ready are both high.

Function
REQ-014 FSM states SHALL be IDLE, TURN, READ and GAP.
REQ-015 IDLE -> TURN when ftdi_rxf_n=0 and buffer occupancy <= FIFO_DEPTH-2.
REQ-016 In TURN, ftdi_oe_n=0 and ftdi_rd_n=1 for exactly one cycle; the FSM then goes to READ.
REQ-017 In READ, ftdi_oe_n=0 and ftdi_rd_n=0; both SHALL be registered outputs.
REQ-018 A word SHALL be written to the buffer on every edge where registered ftdi_rd_n=0 and ftdi_rxf_n=0, capturing ftdi_data and ftdi_be unmodified.
REQ-019 READ -> GAP on the first of: ftdi_rxf_n=1; the session word count reaching BURST_MAX; occupancy after the current edge's write and pop exceeding FIFO_DEPTH-2.
REQ-020 In GAP, ftdi_rd_n=1 and ftdi_oe_n=1 for one cycle; the FSM then goes to IDLE.
REQ-021 The session counter SHALL be 11 bits, cleared on entry to TURN and incremented per captured word; no more than BURST_MAX words are captured per session.
REQ-022 The buffer SHALL never overflow; an FT601 word is captured only under the REQ-018 condition.
REQ-023 The buffer output SHALL be first-word-fall-through: data_out_valid=1 whenever occupancy > 0; data_out holds stable while valid=1 and ready=0.
REQ-024 A simultaneous write and pop SHALL leave occupancy unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-025 Latency from the capturing edge to data_out_valid=1 on an empty buffer SHALL be 1 cycle.
REQ-026 ftdi_rxf_n rising in TURN SHALL still pass through READ for one cycle with no capture, then GAP.

Reset
REQ-027 When rst_n=0: FSM=IDLE, ftdi_oe_n=1, ftdi_rd_n=1, data_out_valid=0, buffer empty, session counter=0.
REQ-028 Reset asserted mid-READ SHALL release the bus (oe_n=1, rd_n=1) immediately and asynchronously; buffered words are discarded.
REQ-029 After rst_n deasserts, no read session SHALL start before the second rising edge.

Structure
REQ-030 Shared package ftdi_pkg SHALL hold the FSM state encoding, the BURST_MAX default (1024) and the bus widths (32 data, 4 BE).
REQ-031 The buffer SHALL be the sub-module rx_sync_fifo: single clock, FWFT, with count output.

Verification
REQ-032 rxf_n=0 continuously, ready=1, 5 words A0..A4 -> oe_n falls 1 cycle before rd_n; data_out = A0..A4 in order; no gaps after the first.
REQ-033 ready=0, FIFO_DEPTH=8, rxf_n=0 -> rd_n rises with occupancy <= 7, never 8+; no word lost or duplicated after ready=1.
REQ-034 rxf_n=0 for 2000 words, ready=1 -> session ends after exactly 1024 captures, GAP and IDLE each for 1 cycle, new session resumes.
REQ-035 rxf_n rises mid-burst after 3 words -> exactly 3 words captured, GAP, IDLE; oe_n=1 within 2 cycles.
REQ-036 rst_n pulled low mid-READ with 4 words buffered -> oe_n=1, rd_n=1, valid=0 immediately; after release, no read for 2 edges.
REQ-037 ftdi_be=4'b0011 on the last word -> data_out_be=4'b0011 for that word; all other words read 4'b1111.
